// File: rtl/song_scheduler.sv
// song_scheduler: steps a note ROM through one of two songs with sound/gap slots, pause/stop and key pre-emption.
// Define LOOP_EN to restart the current song at its end instead of returning to IDLE.
module song_scheduler #(
  parameter int AW          = 8,
  parameter int NW          = 5,
  parameter int BEAT_CYCLES = 12000000,
  parameter int GAP_CYCLES  = 2400000,
  parameter int ROM_LAT     = 1,
  parameter int SONG0_START = 0,
  parameter int SONG0_END   = 47,
  parameter int SONG1_START = 48,
  parameter int SONG1_END   = 83
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          play,
  input  logic          pause,
  input  logic          stop,
  input  logic          song_sel,
  input  logic [NW-1:0] key_note,
  output logic [AW-1:0] addr,
  input  logic [NW-1:0] rom_data,
  output logic [NW-1:0] note,
  output logic          busy,
  output logic          key_active
);
  localparam int CW = $clog2(BEAT_CYCLES + ROM_LAT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, SOUND, GAP, PAUSED} state_t;
`ifdef LOOP_EN
  localparam state_t END_ST = FETCH;
`else
  localparam state_t END_ST = IDLE;
`endif
  state_t state_q, state_d, resume_q, resume_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d, start, last;
  logic [NW-1:0] pnote_q, pnote_d, note_q, note_d;
  logic sel_q, key_q, running, sel_chg;
  assign start   = song_sel ? AW'(SONG1_START) : AW'(SONG0_START);
  assign last    = song_sel ? AW'(SONG1_END) : AW'(SONG0_END);
  assign running = state_q inside {FETCH, SOUND, GAP};
  assign sel_chg = song_sel != sel_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
      cnt_q    <= '0;
      addr_q   <= AW'(SONG0_START);
      pnote_q  <= '0;
      note_q   <= '0;
      sel_q    <= 1'b0;
      key_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      pnote_q  <= pnote_d;
      note_q   <= note_d;
      sel_q    <= song_sel;
      key_q    <= |key_note;
    end
  end
  // Normal advance first; pause, song change and stop then override in rising priority.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    pnote_d  = pnote_q;
    case (state_q)
      IDLE: if (play) begin
        state_d = FETCH;
        cnt_d   = '0;
        addr_d  = start;
      end
      FETCH: if (cnt_q == CW'(ROM_LAT)) begin
        pnote_d = rom_data;
        cnt_d   = '0;
        state_d = &rom_data ? END_ST : SOUND;
        addr_d  = &rom_data ? start : addr_q;
      end else cnt_d = cnt_q + CW'(1);
      SOUND: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BEAT_CYCLES - GAP_CYCLES - 1)) state_d = GAP;
      end
      GAP: if (cnt_q == CW'(BEAT_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = addr_q == last ? END_ST : FETCH;
        addr_d  = addr_q == last ? start : addr_q + AW'(1);
      end else cnt_d = cnt_q + CW'(1);
      PAUSED: if (play) state_d = resume_q;
      default: state_d = IDLE;
    endcase
    if (pause && running && state_d != IDLE) begin
      resume_d = state_d;
      state_d  = PAUSED;
    end
    if (sel_chg) begin
      state_d = state_q == IDLE ? IDLE : FETCH;
      cnt_d   = '0;
      addr_d  = start;
    end
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      addr_d  = start;
    end
  end
  always_comb note_d = |key_note ? key_note : (state_d == SOUND ? pnote_d : '0);
  assign addr       = addr_q;
  assign note       = note_q;
  assign busy       = state_q != IDLE;
  assign key_active = key_q;
endmodule

// File: tb/tb_song_scheduler.sv
// tb_song_scheduler: directed checks of play, end-of-song, pause/resume, key pre-emption, stop and song change.
module tb_song_scheduler;
  localparam int AW = 8;
  localparam int NW = 5;
`ifdef LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, play = 1'b0, pause = 1'b0, stop = 1'b0, song_sel = 1'b0;
  logic [NW-1:0] key_note = '0, rom_data = '0, note;
  logic [AW-1:0] addr;
  logic busy, key_active;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  song_scheduler #(
    .AW(AW), .NW(NW), .BEAT_CYCLES(10), .GAP_CYCLES(2), .ROM_LAT(1),
    .SONG0_START(0), .SONG0_END(3), .SONG1_START(4), .SONG1_END(5)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .song_sel(song_sel),
    .key_note(key_note), .addr(addr), .rom_data(rom_data), .note(note), .busy(busy),
    .key_active(key_active)
  );
  function automatic logic [NW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      8'd0: return 5'd1;
      8'd1: return 5'd2;
      8'd2: return 5'd0;
      8'd3: return 5'd5;
      8'd4: return 5'd7;
      8'd5: return 5'd31;
      default: return 5'd0;
    endcase
  endfunction
  always @(posedge clk) rom_data <= rom_f(addr);
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic start_song(input logic sel);
    stop = 1'b1;
    step();
    stop = 1'b0;
    song_sel = sel;
    step();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(3);
    chk("rst_addr", addr, 0);
    chk("rst_note", note, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key", key_active, 0);
    rst = 1'b0;
    step();
    // song 0: note on cycles 2..9 of each 12-cycle slot
    start_song(1'b0);
    chk("s0_busy0", busy, 1);
    for (int k = 1; k <= 48; k++) begin
      step();
      chk("s0_addr", addr, k < 48 ? k / 12 : 0);
      chk("s0_note", note, (k >= 2 && (k - 2) % 12 < 8) ? rom_f(AW'((k - 2) / 12)) : 0);
    end
    chk("s0_end_busy", busy, LOOP);
    // song 1: end marker at address 5
    start_song(1'b1);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("s1_note", note, (k >= 2 && k <= 9) ? 7 : 0);
      chk("s1_addr", addr, (k >= 12 && k < 14) ? 5 : 4);
      chk("s1_busy", busy, k < 14 ? 1 : LOOP);
    end
    // pause three cycles into the sound of address 1
    start_song(1'b0);
    step(16);
    chk("p_pre", note, 2);
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("p_note0", note, 0);
    chk("p_busy", busy, 1);
    step(20);
    chk("p_hold_note", note, 0);
    chk("p_hold_addr", addr, 1);
    play = 1'b1;
    step();
    play = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("p_resume", note, 2);
      step();
    end
    chk("p_gap", note, 0);
    step(2);
    chk("p_next_addr", addr, 2);
    // live key pre-empts output only
    start_song(1'b0);
    step(3);
    chk("k_pre", note, 1);
    chk("k_pre_act", key_active, 0);
    key_note = 5'd9;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("k_note", note, 9);
      chk("k_act", key_active, 1);
    end
    key_note = '0;
    step();
    chk("k_rel", note, 1);
    chk("k_rel_act", key_active, 0);
    step();
    chk("k_rel2", note, 1);
    step();
    chk("k_gap", note, 0);
    step(4);
    chk("k_next", note, 2);
    chk("k_next_addr", addr, 1);
    // stop beats play in the same cycle
    start_song(1'b0);
    step(5);
    chk("sp_pre", note, 1);
    stop = 1'b1;
    play = 1'b1;
    step();
    stop = 1'b0;
    play = 1'b0;
    chk("sp_busy", busy, 0);
    chk("sp_note", note, 0);
    chk("sp_addr", addr, 0);
    // song change during gap, then play+pause together
    start_song(1'b0);
    step(10);
    chk("sc_gap", note, 0);
    song_sel = 1'b1;
    step();
    chk("sc_addr", addr, 4);
    chk("sc_busy", busy, 1);
    step(2);
    chk("sc_note", note, 7);
    play = 1'b1;
    pause = 1'b1;
    step();
    play = 1'b0;
    pause = 1'b0;
    chk("pp_note", note, 0);
    chk("pp_busy", busy, 1);
    step(3);
    chk("pp_hold", note, 0);
    chk("pp_addr", addr, 4);
    play = 1'b1;
    step();
    play = 1'b0;
    chk("pp_resume", note, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
